// File: rtl/riscv_result_checker_pkg.sv
// Shared types and constants for the end-of-test result checker.
// The first-error record is sized for the widest supported configuration.
package riscv_result_checker_pkg;

  typedef enum logic [2:0] {
    CHK_IDLE     = 3'd0,
    CHK_RUN      = 3'd1,
    CHK_SCAN_RF  = 3'd2,
    CHK_SCAN_MEM = 3'd3,
    CHK_DONE     = 3'd4
  } checker_state_t;

  localparam logic REGION_RF  = 1'b0;
  localparam logic REGION_MEM = 1'b1;

  localparam int CHK_TIMEOUT   = 500;
  localparam int CHK_NB_ERRCNT = 16;

  // Upper bounds for NB_DATA / NB_MADDR; narrower configurations zero-extend.
  localparam int CHK_MAX_DATA  = 64;
  localparam int CHK_MAX_MADDR = 32;

  typedef struct packed {
    logic                     region;
    logic [CHK_MAX_MADDR-1:0] addr;
    logic [CHK_MAX_DATA-1:0]  exp;
    logic [CHK_MAX_DATA-1:0]  got;
  } chk_ferr_t;

endpackage

// File: rtl/riscv_chk_compare.sv
// One-stage compare pipeline: registered issue tag, comparator,
// saturating mismatch counter and first-mismatch capture.
module riscv_chk_compare
  import riscv_result_checker_pkg::*;
#(
  parameter int NB_DATA   = 32,
  parameter int NB_MADDR  = 8,
  parameter int NB_ERRCNT = CHK_NB_ERRCNT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_issue_valid,
  input  logic                 i_issue_region,
  input  logic [NB_MADDR-1:0]  i_issue_addr,
  input  logic [NB_DATA-1:0]   i_rf_data,
  input  logic [7:0]           i_mem_data,
  input  logic [NB_DATA-1:0]   i_exp_data,
  output logic [NB_ERRCNT-1:0] o_err_count,
  output logic [NB_ERRCNT-1:0] o_err_count_next,
  output logic                 o_ferr_valid,
  output chk_ferr_t            o_ferr
);

  logic                 tag_valid_q, tag_valid_d;
  logic                 tag_region_q, tag_region_d;
  logic [NB_MADDR-1:0]  tag_addr_q, tag_addr_d;
  logic [NB_ERRCNT-1:0] err_q, err_d;
  logic                 ferr_valid_q, ferr_valid_d;
  chk_ferr_t            ferr_q, ferr_d;

  logic [NB_DATA-1:0]   got_word;
  logic [NB_DATA-1:0]   exp_word;
  logic                 mismatch;

  // Memory entries are bytes: only the low expected byte takes part.
  always_comb begin
    got_word = i_rf_data;
    exp_word = i_exp_data;
    if (tag_region_q == REGION_MEM) begin
      got_word = NB_DATA'(i_mem_data);
      exp_word = NB_DATA'(i_exp_data[7:0]);
    end
    mismatch = tag_valid_q && (got_word != exp_word);
  end

  always_comb begin
    tag_valid_d  = i_issue_valid;
    tag_region_d = i_issue_region;
    tag_addr_d   = i_issue_addr;
    err_d        = err_q;
    ferr_valid_d = ferr_valid_q;
    ferr_d       = ferr_q;
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + NB_ERRCNT'(1);
      if (!ferr_valid_q) begin
        ferr_valid_d  = 1'b1;
        ferr_d.region = tag_region_q;
        ferr_d.addr   = CHK_MAX_MADDR'(tag_addr_q);
        ferr_d.exp    = CHK_MAX_DATA'(exp_word);
        ferr_d.got    = CHK_MAX_DATA'(got_word);
      end
    end
    if (i_clear) begin
      tag_valid_d  = 1'b0;
      err_d        = '0;
      ferr_valid_d = 1'b0;
      ferr_d       = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tag_valid_q  <= 1'b0;
      tag_region_q <= REGION_RF;
      tag_addr_q   <= '0;
      err_q        <= '0;
      ferr_valid_q <= 1'b0;
      ferr_q       <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_region_q <= tag_region_d;
      tag_addr_q   <= tag_addr_d;
      err_q        <= err_d;
      ferr_valid_q <= ferr_valid_d;
      ferr_q       <= ferr_d;
    end
  end

  assign o_err_count      = err_q;
  assign o_err_count_next = err_d;
  assign o_ferr_valid     = ferr_valid_q;
  assign o_ferr           = ferr_q;

endmodule

// File: rtl/riscv_result_checker.sv
// End-of-test checker: waits for halt or timeout, then scans RF and DMEM
// against an expected image and reports pass/fail plus the first mismatch.
module riscv_result_checker
  import riscv_result_checker_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int N_REGS         = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int NB_MADDR       = $clog2(MEM_DEPTH),
  parameter int TIMEOUT_CYCLES = CHK_TIMEOUT,
  parameter int NB_ERRCNT      = CHK_NB_ERRCNT
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_mem_check_en,
  input  logic                      i_halt,
  output logic [$clog2(N_REGS)-1:0] o_rf_addr,
  input  logic [NB_DATA-1:0]        i_rf_data,
  output logic [NB_MADDR-1:0]       o_mem_addr,
  input  logic [7:0]                i_mem_data,
  output logic                      o_exp_sel,
  output logic [NB_MADDR-1:0]       o_exp_addr,
  input  logic [NB_DATA-1:0]        i_exp_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic                      o_timeout,
  output logic [NB_ERRCNT-1:0]      o_err_count,
  output logic                      o_ferr_valid,
  output logic                      o_ferr_region,
  output logic [NB_MADDR-1:0]       o_ferr_addr,
  output logic [NB_DATA-1:0]        o_ferr_exp,
  output logic [NB_DATA-1:0]        o_ferr_got,
  output checker_state_t            o_dbg_state
);

  localparam int NB_RADDR = $clog2(N_REGS);
  localparam int NB_CYC   = $clog2(TIMEOUT_CYCLES + 1);
  // The shared scan counter assumes N_REGS <= MEM_DEPTH.
  localparam logic [NB_MADDR-1:0] LAST_REG  = NB_MADDR'(N_REGS - 1);
  localparam logic [NB_MADDR-1:0] LAST_BYTE = NB_MADDR'(MEM_DEPTH - 1);
  localparam logic [NB_CYC-1:0]   LAST_CYC  = NB_CYC'(TIMEOUT_CYCLES - 1);

  checker_state_t       state_q, state_d;
  logic [NB_CYC-1:0]    cyc_q, cyc_d;
  logic [NB_MADDR-1:0]  addr_q, addr_d;
  logic                 drain_q, drain_d;
  logic                 mem_en_q, mem_en_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic                 clear;
  logic                 issue_valid;
  logic                 issue_region;
  logic [NB_ERRCNT-1:0] err_next;
  chk_ferr_t            ferr;
  logic                 unused_ferr;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    mem_en_d     = mem_en_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    pass_d       = pass_q;
    clear        = 1'b0;
    issue_valid  = 1'b0;
    issue_region = REGION_RF;
    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (i_start) begin
          state_d   = CHK_RUN;
          cyc_d     = '0;
          addr_d    = '0;
          drain_d   = 1'b0;
          mem_en_d  = i_mem_check_en;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          clear     = 1'b1;
        end
      end
      CHK_RUN: begin
        cyc_d = cyc_q + NB_CYC'(1);
        if (i_halt) begin
          state_d = CHK_SCAN_RF;
          addr_d  = '0;
        end else if (cyc_q == LAST_CYC) begin
          timeout_d = 1'b1;
          state_d   = CHK_SCAN_RF;
          addr_d    = '0;
        end
      end
      CHK_SCAN_RF, CHK_SCAN_MEM: begin
        // The drain cycle lets the final issued address reach the comparator.
        if (drain_q) begin
          state_d = CHK_DONE;
          drain_d = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0) && !timeout_q;
        end else if (state_q == CHK_SCAN_RF) begin
          issue_valid  = 1'b1;
          issue_region = REGION_RF;
          if (addr_q == LAST_REG) begin
            addr_d = '0;
            if (mem_en_q) state_d = CHK_SCAN_MEM;
            else          drain_d = 1'b1;
          end else begin
            addr_d = addr_q + NB_MADDR'(1);
          end
        end else begin
          issue_valid  = 1'b1;
          issue_region = REGION_MEM;
          if (addr_q == LAST_BYTE) begin
            addr_d  = '0;
            drain_d = 1'b1;
          end else begin
            addr_d = addr_q + NB_MADDR'(1);
          end
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= CHK_IDLE;
      cyc_q     <= '0;
      addr_q    <= '0;
      drain_q   <= 1'b0;
      mem_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      mem_en_q  <= mem_en_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  riscv_chk_compare #(
    .NB_DATA   (NB_DATA),
    .NB_MADDR  (NB_MADDR),
    .NB_ERRCNT (NB_ERRCNT)
  ) u_compare (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_clear          (clear),
    .i_issue_valid    (issue_valid),
    .i_issue_region   (issue_region),
    .i_issue_addr     (addr_q),
    .i_rf_data        (i_rf_data),
    .i_mem_data       (i_mem_data),
    .i_exp_data       (i_exp_data),
    .o_err_count      (o_err_count),
    .o_err_count_next (err_next),
    .o_ferr_valid     (o_ferr_valid),
    .o_ferr           (ferr)
  );

  assign o_rf_addr     = addr_q[NB_RADDR-1:0];
  assign o_mem_addr    = addr_q;
  assign o_exp_addr    = addr_q;
  assign o_exp_sel     = (state_q == CHK_SCAN_MEM);
  assign o_busy        = (state_q == CHK_RUN) || (state_q == CHK_SCAN_RF) ||
                         (state_q == CHK_SCAN_MEM);
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_timeout     = timeout_q;
  assign o_ferr_region = ferr.region;
  assign o_ferr_addr   = ferr.addr[NB_MADDR-1:0];
  assign o_ferr_exp    = ferr.exp[NB_DATA-1:0];
  assign o_ferr_got    = ferr.got[NB_DATA-1:0];
  assign o_dbg_state   = state_q;
  // Upper record bits stay zero in narrower configurations.
  assign unused_ferr   = ^ferr;

endmodule
